// File: rtl/hall_call_encoder.sv
// hall_call_encoder: hall-call panel front end for the lift call interface.
// Latches the six hall buttons, lights their lamps, arbitrates pending calls
// round-robin and presents one call at a time as a 3-bit code. A call clears
// once the lift floor has matched the call's floor long enough and the code
// has been held for its minimum time.
// Optional build macro: CALL_TIMEOUT_EN re-queues a call left unserved for
// TIMEOUT cycles of presentation.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | nothing presented; waits for any pending call
// S_SELECT | picks the next pending call round-robin from rr_ptr
// S_PRESENT| drives call_code/call_valid; waits for service (or timeout)
module hall_call_encoder #(
  parameter int ARRIVE_CYCLES = 2,
  parameter int MIN_HOLD      = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn,
  input  logic [1:0] lift_floor,
  output logic [2:0] call_code,
  output logic       call_valid,
  output logic [5:0] lamp
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SELECT  = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  localparam int AW = $clog2(ARRIVE_CYCLES + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [AW-1:0] ARR_MAX  = AW'(ARRIVE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  logic [1:0]    state;
  logic [5:0]    btn_q;
  logic [5:0]    pending;
  logic [2:0]    rr_ptr;
  logic [2:0]    sel;
  logic [2:0]    pick;
  logic [2:0]    sel_next;
  logic [AW-1:0] arr_cnt;
  logic [HW-1:0] hold_cnt;
  logic          served;
  logic          floor_match;
  logic [5:0]    clr_mask;

  function automatic logic [2:0] enc(input logic [2:0] idx);
    case (idx)
      3'd0:    enc = 3'b001;
      3'd1:    enc = 3'b010;
      3'd2:    enc = 3'b011;
      3'd3:    enc = 3'b110;
      3'd4:    enc = 3'b111;
      3'd5:    enc = 3'b100;
      default: enc = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] target(input logic [2:0] idx);
    case (idx)
      3'd0:       target = 2'b00;
      3'd1, 3'd3: target = 2'b01;
      3'd2, 3'd4: target = 2'b10;
      default:    target = 2'b11;
    endcase
  endfunction

  // Round-robin scan of pending starting at rr_ptr, wrapping mod 6.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    sum   = 4'd0;
    idx   = 3'd0;
    for (int i = 0; i < 6; i++) begin
      sum = {1'b0, rr_ptr} + 4'(i);
      idx = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
      if (!found && pending[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign sel_next    = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
  assign floor_match = (lift_floor == target(sel));
  assign served      = (state == S_PRESENT) && (arr_cnt == ARR_MAX) && (hold_cnt == HOLD_MAX);
  assign clr_mask    = served ? (6'b000001 << sel) : 6'b000000;
  assign lamp        = pending;

  // Button edge capture; a clear on the serve cycle wins over a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= 6'b0;
      pending <= 6'b0;
    end else begin
      btn_q   <= btn;
      pending <= (pending | (btn & ~btn_q)) & ~clr_mask;
    end
  end

`ifdef CALL_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt;
  logic          timed_out;

  assign timed_out = (state == S_PRESENT) && !served && (tmo_cnt == TMO_LAST);

  // Presentation timer; cleared on each new selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   tmo_cnt <= '0;
    else if (state == S_SELECT)   tmo_cnt <= '0;
    else if (state == S_PRESENT)  tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic timed_out;
  logic unused_timeout;
  assign timed_out      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Sequencer: selection, dwell/hold counting, registered call outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= 3'd0;
      sel        <= 3'd0;
      arr_cnt    <= '0;
      hold_cnt   <= '0;
      call_code  <= 3'b000;
      call_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          call_code  <= 3'b000;
          call_valid <= 1'b0;
          if (pending != 6'b0) state <= S_SELECT;
        end
        S_SELECT: begin
          sel        <= pick;
          arr_cnt    <= '0;
          hold_cnt   <= '0;
          call_code  <= enc(pick);
          call_valid <= 1'b1;
          state      <= S_PRESENT;
        end
        S_PRESENT: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          if (!floor_match)          arr_cnt <= '0;
          else if (arr_cnt != ARR_MAX) arr_cnt <= arr_cnt + 1'b1;
          if (served || timed_out) begin
            rr_ptr     <= sel_next;
            call_code  <= 3'b000;
            call_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          call_code  <= 3'b000;
          call_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hall_call_encoder.sv
// Directed bench for hall_call_encoder: capture latency, round-robin order,
// floor dwell, re-press on the serve cycle, async reset and held/timeout calls.
module tb_hall_call_encoder;

  logic       clk;
  logic       rst_n;
  logic [5:0] btn;
  logic [1:0] lift_floor;
  logic [2:0] call_code;
  logic       call_valid;
  logic [5:0] lamp;

  int vectors;
  int errors;

  hall_call_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .lift_floor (lift_floor),
    .call_code  (call_code),
    .call_valid (call_valid),
    .lamp       (lamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] rr_code [6];
  logic [1:0] rr_floor[6];
  logic [5:0] rr_lamp [6];

  initial begin
    vectors = 0;
    errors  = 0;
    rr_code  = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
    rr_floor = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
    rr_lamp  = '{6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000};

    rst_n = 1'b0;
    btn = 6'b0;
    lift_floor = 2'b00;
    #12;
    check("rst_code",  {5'b0, call_code}, 8'h00);
    check("rst_valid", {7'b0, call_valid}, 8'h00);
    check("rst_lamp",  {2'b0, lamp}, 8'h00);
    rst_n = 1'b1;
    tick();

    // 1: single 1U call, lift already at F1
    btn = 6'b000001;
    tick();
    check("t1_lamp_p1",  {2'b0, lamp}, 8'h01);
    check("t1_valid_p1", {7'b0, call_valid}, 8'h00);
    btn = 6'b0;
    tick();
    check("t1_valid_p2", {7'b0, call_valid}, 8'h00);
    tick();
    check("t1_code_p3",  {5'b0, call_code}, 8'h01);
    check("t1_valid_p3", {7'b0, call_valid}, 8'h01);
    repeat (4) tick();
    check("t1_held", {4'b0, call_valid, call_code}, 8'h09);
    tick();
    check("t1_clr_valid", {7'b0, call_valid}, 8'h00);
    check("t1_clr_code",  {5'b0, call_code}, 8'h00);
    check("t1_clr_lamp",  {2'b0, lamp}, 8'h00);

    // 2: 2U and 4D together, lift at F4; 2U first (rr_ptr=1)
    lift_floor = 2'b11;
    btn = 6'b100010;
    tick();
    check("t2_lamp", {2'b0, lamp}, 8'h22);
    btn = 6'b0;
    tick();
    tick();
    check("t2_code_2u", {4'b0, call_valid, call_code}, 8'h0A);
    repeat (4) tick();
    check("t2_wait_floor", {4'b0, call_valid, call_code}, 8'h0A);
    lift_floor = 2'b01;
    tick();
    tick();
    check("t2_dwell", {4'b0, call_valid, call_code}, 8'h0A);
    tick();
    check("t2_2u_clr_valid", {7'b0, call_valid}, 8'h00);
    check("t2_2u_clr_lamp",  {2'b0, lamp}, 8'h20);
    tick();
    tick();
    check("t2_code_4d", {4'b0, call_valid, call_code}, 8'h0C);
    lift_floor = 2'b11;
    repeat (4) tick();
    check("t2_4d_held", {4'b0, call_valid, call_code}, 8'h0C);
    tick();
    check("t2_4d_clr", {2'b0, lamp}, 8'h00);
    check("t2_4d_clr_valid", {7'b0, call_valid}, 8'h00);

    // 3: all six pressed, served in round-robin order from rr_ptr=0
    btn = 6'b111111;
    tick();
    check("t3_lamp_all", {2'b0, lamp}, 8'h3F);
    btn = 6'b0;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t3_code_%0d", k), {4'b0, call_valid, call_code}, {4'b0, 1'b1, rr_code[k]});
      lift_floor = rr_floor[k];
      repeat (5) tick();
      check($sformatf("t3_lamp_%0d", k), {1'b0, call_valid, lamp}, {2'b0, rr_lamp[k]});
      if (k < 5) begin
        tick();
        tick();
      end
    end

    // 4: re-press 3D on its serve cycle; clear wins, held level does not relight
    btn = 6'b010000;
    tick();
    btn = 6'b0;
    tick();
    tick();
    check("t4_code_3d", {4'b0, call_valid, call_code}, 8'h0F);
    lift_floor = 2'b10;
    repeat (4) tick();
    btn = 6'b010000;
    tick();
    check("t4_serve_lamp", {1'b0, call_valid, lamp}, 8'h00);
    repeat (3) tick();
    check("t4_held_lamp", {1'b0, call_valid, lamp}, 8'h00);
    btn = 6'b0;
    tick();
    btn = 6'b010000;
    tick();
    check("t4_relight", {2'b0, lamp}, 8'h10);
    btn = 6'b0;

    // 5: async reset in the middle of presenting 3D
    tick();
    tick();
    check("t5_code_pre", {4'b0, call_valid, call_code}, 8'h0F);
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_code",  {5'b0, call_code}, 8'h00);
    check("t5_rst_valid", {7'b0, call_valid}, 8'h00);
    check("t5_rst_lamp",  {2'b0, lamp}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("t5_post_lamp", {1'b0, call_valid, lamp}, 8'h00);

    // 6: serve 3U to move rr_ptr to 3, then 2D+3U with no floor match
    lift_floor = 2'b10;
    btn = 6'b000100;
    tick();
    btn = 6'b0;
    tick();
    tick();
    check("t6_code_3u", {4'b0, call_valid, call_code}, 8'h0B);
    repeat (5) tick();
    check("t6_3u_clr", {1'b0, call_valid, lamp}, 8'h00);
    lift_floor = 2'b00;
    btn = 6'b001100;
    tick();
    btn = 6'b0;
    check("t6_lamp", {2'b0, lamp}, 8'h0C);
    tick();
    tick();
    check("t6_code_2d", {4'b0, call_valid, call_code}, 8'h0E);
`ifdef CALL_TIMEOUT_EN
    repeat (63) tick();
    check("t6_tmo_pre", {4'b0, call_valid, call_code}, 8'h0E);
    tick();
    check("t6_tmo_drop", {1'b0, call_valid, lamp}, 8'h0C);
    tick();
    tick();
    check("t6_tmo_3u", {4'b0, call_valid, call_code}, 8'h0B);
    check("t6_tmo_lamp3", {7'b0, lamp[3]}, 8'h01);
`else
    repeat (100) tick();
    check("t6_hold_2d", {4'b0, call_valid, call_code}, 8'h0E);
    check("t6_hold_lamp", {2'b0, lamp}, 8'h0C);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
